fixed_log: RTL and testbench
============================

Name: fixed_log

Overview:
- Sequential fixed-point natural logarithm. It is the inverse of the team's fixed_exp datapath.
- Accepts an unsigned 5.5 value r (bits [4:-5]) and returns x = ln(r) in unsigned 3.7 format (bits [2:-7]).
- Uses greedy multiplicative normalisation over the same nine factor set and ln-constant table as the exponential block, one factor per clock.
- Used to recover exponents from exp outputs and for round-trip checking of the exp path.

Parameters:
N_ITER, 9, number of factor iterations performed; legal 1..9, always taken in table order from index 0.
ROUND, 0, output quantisation: 0 = truncate accumulator to 3.7, 1 = round half-up to 3.7, saturating at 1023.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when ready=1
r  input  10  operand, unsigned 5.5, bits [4:-5]
ready  output  1  high in IDLE; start accepted only while high
done  output  1  one-cycle pulse when x/err are updated
x  output  10  result ln(r), unsigned 3.7, bits [2:-7]; held until next done
err  output  1  high with result when r < 1.0 (r[4:0]==0); x=0 in that case

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, x=0, err=0, internal y/acc/index cleared.
- Constant table (32-bit, 3.29), index i : factor f_i : ln(f_i):
  - 0 : 5 : 0x33808400
  - 1 : 3 : 0x2327D500
  - 2 : 2 : 0x162E4300
  - 3 : 1.5 : 0x0CF991F0
  - 4 : 1.25 : 0x0723FDF0
  - 5 : 1.125 : 0x03C4E0EC
  - 6 : 1.0625 : 0x01F0A30C
  - 7 : 1.03125 : 0x00FC14D8
  - 8 : 1.015625 : 0x007F02A3
- Factor products are shift/add only, with no multiplier: y+4y, y+2y, 2y, y+(y>>1), y+(y>>2) ... y+(y>>6).
- Datapath widths:
  - y is 37 bits unsigned [7:-29] so that candidates never overflow.
  - acc is 32 bits [2:-29].
  - r is compared as r zero-extended and shifted left 24 to align with y.
- State IDLE:
  - ready=1.
  - On a clock edge with start=1, latch r into the operand register, set y=1.0, acc=0, i=0, go to ITER, ready=0.
- State ITER (N_ITER cycles, one per i):
  - cand = y*f_i.
  - If cand <= r_aligned: y=cand and acc=acc+ln(f_i); otherwise y and acc are unchanged.
  - i increments each cycle; after i=N_ITER-1, go to FINISH.
  - Equality accepts the factor, so exact powers are reached.
- State FINISH (1 cycle):
  - x = acc[2:-7] (truncated), or rounded using acc bit -8 when ROUND=1.
  - err = (operand < 1.0).
  - done=1 for exactly this following cycle; return to IDLE with ready=1 in the same edge.
- Latency: start sampled at edge k, done high during the cycle after edge k+N_ITER+1, i.e. 11 cycles for the default. Fixed latency regardless of operand.
- Back-to-back: start may be high in the same cycle that done is high; it is accepted because ready=1 then.
- start while ready=0 is ignored; it is neither queued nor an error. r changes after acceptance do not affect the result.
- r < 1.0, including r=0: the iterations still run, no factor is accepted, x=0, err=1, same latency.
- r = 1.0: x=0, err=0.
- Maximum input r = 31.96875: result is within 2 LSB of 443; no overflow, since ln(32) < 7.99.
- Accuracy: for r >= 1.0 with N_ITER=9, |x - ln(r)*128| <= 2 LSB.
- Reset asserted mid-operation aborts immediately: outputs return to reset values and no done is produced.

Test Plan:
- Reset then r=10'b00001_00000 (1.0), pulse start -> done exactly 11 cycles later, x=0, err=0; ready low for 10 cycles.
- r=2.0 (0x040) -> only factor i=2 accepted, x=88 (0.6875), err=0; r=5.0 (0x0A0) -> x=206.
- r=15.0 (0x1E0) -> factors 5 and 3 accepted, x=346 (acc=0x56A85900); with ROUND=1 -> x=347.
- r=0x010 (0.5) and r=0 -> x=0, err=1, done after 11 cycles; a following r=1.0 request clears err.
- Start held high continuously with r stepping 1.0..31.96875 -> one done per 11 cycles, every x within ±2 LSB of round(ln(r)*128); no starts accepted while busy.
- Assert rst 4 cycles after start -> ready=1, done=0, x=0 immediately (asynchronously); no done pulse is seen afterwards; a fresh request completes normally.

Source files
------------

// File: rtl/fixed_log.sv
// fixed_log: sequential ln(r) via greedy multiplicative normalisation, 5.5 in, 3.7 out
module fixed_log #(
  parameter int N_ITER = 9,
  parameter bit ROUND = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] r,
  output logic       ready,
  output logic       done,
  output logic [9:0] x,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
  state_t state, state_n;
  logic [9:0] op;
  logic [36:0] y, cand, r_al;
  logic [31:0] acc, lnf;
  logic [3:0] i;
  logic [10:0] rnd;
  logic [9:0] xr;
  logic unused_lsbs;
  assign unused_lsbs = ^acc[20:0];
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state and handshake
  always_comb begin
    state_n = state;
    ready = state == IDLE;
    if (state == IDLE && start) state_n = ITER;
    if (state == ITER && i == 4'(N_ITER - 1)) state_n = FINISH;
    if (state == FINISH) state_n = IDLE;
  end
  // ln(f_i) table in 3.29
  always_comb begin
    lnf = 32'd0;
    case (i)
      4'd0: lnf = 32'h33808400;
      4'd1: lnf = 32'h2327D500;
      4'd2: lnf = 32'h162E4300;
      4'd3: lnf = 32'h0CF991F0;
      4'd4: lnf = 32'h0723FDF0;
      4'd5: lnf = 32'h03C4E0EC;
      4'd6: lnf = 32'h01F0A30C;
      4'd7: lnf = 32'h00FC14D8;
      4'd8: lnf = 32'h007F02A3;
      default: lnf = 32'd0;
    endcase
  end
  // candidate y*f_i by shift/add, aligned operand, output quantisation
  always_comb begin
    cand = i == 4'd0 ? y + (y << 2) :
           i == 4'd1 ? y + (y << 1) :
           i == 4'd2 ? y << 1 : y + (y >> (i - 4'd2));
    r_al = {27'd0, op} << 24;
    rnd = {1'b0, acc[31:22]} + 11'(ROUND && acc[21]);
    xr = rnd[10] ? 10'h3FF : rnd[9:0];
  end
  // datapath: operand latch, factor iterations, result update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op <= '0;
      y <= '0;
      acc <= '0;
      i <= '0;
      x <= '0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE && start) begin
        op <= r;
        y <= 37'd1 << 29;
        acc <= '0;
        i <= '0;
      end
      if (state == ITER) begin
        if (cand <= r_al) begin
          y <= cand;
          acc <= acc + lnf;
        end
        i <= i + 4'd1;
      end
      if (state == FINISH) begin
        x <= xr;
        err <= op[9:5] == 5'd0;
      end
    end
endmodule

// File: tb/tb_fixed_log.sv
// tb_fixed_log: directed checks of fixed_log latency, results, errors and reset abort
module tb_fixed_log;
  logic clk = 1'b0;
  logic rst, start;
  logic [9:0] r;
  logic ready, done, err, ready1, done1, err1;
  logic [9:0] x, x1;
  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] xo, xo1;
  logic eo;
  int lat, rlow, cnt;

  always #5 clk = ~clk;

  fixed_log #(.N_ITER(9), .ROUND(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start), .r(r),
    .ready(ready), .done(done), .x(x), .err(err)
  );
  fixed_log #(.N_ITER(9), .ROUND(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .r(r),
    .ready(ready1), .done(done1), .x(x1), .err(err1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // greedy normalisation in real arithmetic with exact ln values
  function automatic int model(input int rv);
    real f[9] = '{5.0, 3.0, 2.0, 1.5, 1.25, 1.125, 1.0625, 1.03125, 1.015625};
    real rr, y, a;
    rr = rv / 32.0;
    y = 1.0;
    a = 0.0;
    for (int k = 0; k < 9; k++)
      if (y * f[k] <= rr) begin
        y = y * f[k];
        a = a + $ln(f[k]);
      end
    return int'($floor(a * 128.0));
  endfunction

  // called just after a negedge with ready expected high; returns at the done negedge
  task automatic run(input logic [9:0] rv, input bit hold, output logic [9:0] xa,
                     output logic [9:0] xb, output logic e, output int l, output int rl);
    r = rv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    r = ~rv;
    l = 0;
    rl = 0;
    do begin
      @(negedge clk);
      l++;
      if (!ready) rl++;
    end while (!done && l < 40);
    xa = x;
    xb = x1;
    e = err;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    r = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_x", x, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    run(10'h020, 0, xo, xo1, eo, lat, rlow);
    check("one_lat", lat, 11);
    check("one_ready_low", rlow, 10);
    check("one_x", xo, 0);
    check("one_err", eo, 0);
    run(10'h040, 0, xo, xo1, eo, lat, rlow);
    check("two_x", xo, 88);
    check("two_err", eo, 0);
    run(10'h0A0, 0, xo, xo1, eo, lat, rlow);
    check("five_x", xo, 206);
    check("five_x_round", xo1, 206);
    run(10'h1E0, 0, xo, xo1, eo, lat, rlow);
    check("fifteen_x", xo, 346);
    check("fifteen_x_round", xo1, 347);
    check("fifteen_lat", lat, 11);
    run(10'h010, 0, xo, xo1, eo, lat, rlow);
    check("half_x", xo, 0);
    check("half_err", eo, 1);
    check("half_lat", lat, 11);
    run(10'h000, 0, xo, xo1, eo, lat, rlow);
    check("zero_x", xo, 0);
    check("zero_err", eo, 1);
    check("zero_lat", lat, 11);
    run(10'h020, 0, xo, xo1, eo, lat, rlow);
    check("err_clear", eo, 0);
    check("err_clear_x", xo, 0);
    run(10'h3FF, 0, xo, xo1, eo, lat, rlow);
    check_near("max_x", xo, 441, 445);
    check("max_err", eo, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    for (int v = 32; v < 1024; v++) begin
      run(10'(v), 1, xo, xo1, eo, lat, rlow);
      check("sweep_lat", lat, 11);
      check("sweep_err", eo, 0);
      check_near("sweep_x", xo, model(v) - 1, model(v));
    end
    start = 1'b0;
    @(negedge clk);
    run(10'h0A0, 0, xo, xo1, eo, lat, rlow);
    check("pre_abort_x", xo, 206);
    r = 10'h1E0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_ready", ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_x", x, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run(10'h040, 0, xo, xo1, eo, lat, rlow);
    check("post_abort_x", xo, 88);
    check("post_abort_lat", lat, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
